// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit.
// Samples bit centres after a 2-flop line synchronizer; error flags pulse alongside rx_done.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_error
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             rx_p0, rx_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bad;
  logic             bit_tick;
  logic             shift, par_chk, done_nxt, perr_nxt, ferr_nxt;

  // Start bit is checked at its centre; every later bit one full period on.
  always_comb begin
    if (state == START) bit_tick = (baud_cnt == CNT_W'(HALF - 1));
    else                bit_tick = (baud_cnt == CNT_W'(CPB - 1));
  end

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    par_chk   = 1'b0;
    done_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE:      if (rx_enable && !rx_s) state_nxt = START;
      START:     if (bit_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_tick) begin
                   shift = 1'b1;
                   if (bit_cnt == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                 end
      PARITY:    if (bit_tick) begin
                   par_chk   = 1'b1;
                   state_nxt = STOP;
                 end
      STOP:      if (bit_tick) begin
                   done_nxt  = 1'b1;
                   perr_nxt  = par_bad;
                   ferr_nxt  = !rx_s;
                   state_nxt = rx_s ? IDLE : WAIT_IDLE;
                 end
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // Losing the enable mid-frame drops the frame silently.
    if (state != IDLE && !rx_enable) begin
      state_nxt = IDLE;
      shift     = 1'b0;
      par_chk   = 1'b0;
      done_nxt  = 1'b0;
      perr_nxt  = 1'b0;
      ferr_nxt  = 1'b0;
    end
  end

  // p0 -> s: line synchronizer, then control state and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rx_p0         <= 1'b1;
      rx_s          <= 1'b1;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      par_bad       <= 1'b0;
      rx_data       <= 8'h00;
      rx_done       <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      rx_error      <= 1'b0;
    end else begin
      state         <= state_nxt;
      rx_p0         <= rx;
      rx_s          <= rx_p0;
      rx_done       <= done_nxt;
      parity_error  <= perr_nxt;
      framing_error <= ferr_nxt;
      rx_error      <= perr_nxt | ferr_nxt;
      if (done_nxt) rx_data <= shreg;

      if (state == IDLE || state == WAIT_IDLE || bit_tick || state_nxt != state)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (state == IDLE)  bit_cnt <= '0;
      else if (shift)     bit_cnt <= bit_cnt + 1'b1;

      if (state == IDLE)  par_bad <= 1'b0;
      else if (par_chk)   par_bad <= (rx_s != ((^shreg) ^ (PARITY_ODD != 0)));
    end
  end

  always_ff @(posedge clk) begin
    if (shift) shreg <= {rx_s, shreg[7:1]};
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), legal only when >= 4.
REQ-003 SHALL have parameter PARITY_EN, default 1, meaning 1 = parity bit present between data and stop.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have port rx_enable, input, 1 bit: receiver enable from the control register.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-010 SHALL have port rx_done, output, 1 bit: single-cycle frame-complete pulse.
REQ-011 SHALL have port rx_busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port parity_error, output, 1 bit: single-cycle pulse.
REQ-013 SHALL have port framing_error, output, 1 bit: single-cycle pulse.
REQ-014 SHALL have port rx_error, output, 1 bit: single-cycle pulse equal to parity_error OR framing_error.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer preset to 1; all decisions use the synchronized value (rx_s).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; rx_busy = (state != IDLE).
REQ-017 IDLE: with rx_enable=1 and rx_s=0, SHALL go to START and clear the bit counter; with rx_enable=0, SHALL remain in IDLE.
REQ-018 START: after CLKS_PER_BIT/2 cycles SHALL resample rx_s; if 0 go to DATA; if 1 (glitch) return to IDLE with no pulses.
REQ-019 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: one sample after CLKS_PER_BIT cycles; expected bit = XOR(data) XOR PARITY_ODD; mismatch is recorded internally until STOP.
REQ-021 STOP: one sample after CLKS_PER_BIT cycles; in the same cycle SHALL pulse rx_done, load rx_data, and pulse parity_error if a mismatch was recorded.
REQ-022 STOP with sampled 0 SHALL also pulse framing_error and go to WAIT_IDLE; with sampled 1 SHALL go to IDLE.
REQ-023 WAIT_IDLE SHALL stay until rx_s=1, then go to IDLE, so a break condition cannot retrigger a frame.
REQ-024 rx_done SHALL pulse on every completed frame, including frames with errors; rx_data SHALL change only in that cycle.
REQ-025 rx_enable deasserted in any non-IDLE state SHALL abort to IDLE on the next edge, with no pulses and rx_data unchanged.
REQ-026 The baud counter SHALL be CLOG2(CLKS_PER_BIT)+1 bits wide and reload to 0 on each sample; it SHALL not wrap inside a bit.
REQ-027 rx_done, parity_error, framing_error and rx_error SHALL each be high for exactly one clk cycle per event and never in consecutive cycles.

Reset
REQ-028 reset=1 at a clk edge SHALL force state IDLE, counters 0, synchronizer 1, rx_data=8'h00, and rx_done/rx_busy/parity_error/framing_error/rx_error=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; reset SHALL take priority over all other inputs.

Verification (CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16)
REQ-030 Frame 0x A5 with even parity bit 0 and stop bit 1 -> rx_data=8'hA5 and one rx_done pulse, no error pulses, rx_busy low after the stop sample.
REQ-031 Frame 0x A5 with parity bit 1 -> rx_done, parity_error and rx_error pulse in the same cycle, rx_data=8'hA5.
REQ-032 Frame 0x3C with stop bit 0, then rx held low for 40 cycles -> framing_error pulse, state WAIT_IDLE, and no new frame until rx returns high.
REQ-033 rx low for 5 cycles then high -> return to IDLE with no pulses, rx_busy high for 5 to 8 cycles at most.
REQ-034 rx_enable dropped during data bit 3 -> IDLE next edge, rx_data keeps its previous value, no pulses.
REQ-035 reset pulsed during DATA, then a full 0x5A frame -> rx_data=8'h5A and only one rx_done pulse, for the post-reset frame.
